// File: rtl/hazard_tracker.sv
// Hazard/forwarding unit: tracks decoder metadata through E/M/W and derives stall plus forwarding selects.
// Optional macro ERET_EPC_STALL_EN adds an eret stall while an mtc0 to EPC is still in E or M.
module hazard_tracker #(
    parameter logic [4:0] EPC_ADDR = 5'd14,
    parameter int         IC_W     = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [IC_W-1:0] ic_d,
    input  logic [5:0]      A1_d,
    input  logic [5:0]      A2_d,
    input  logic [5:0]      A3_d,
    input  logic            iseret_d,
    output logic            stall,
    output logic [1:0]      fwd_rs_d,
    output logic [1:0]      fwd_rt_d,
    output logic [1:0]      fwd_rs_e,
    output logic [1:0]      fwd_rt_e,
    output logic            fwd_rt_m
);

    typedef enum logic [IC_W-1:0] {
        hzd_nop       = IC_W'(0),
        hzd_cal_r     = IC_W'(1),
        hzd_cal_i     = IC_W'(2),
        hzd_load      = IC_W'(3),
        hzd_store     = IC_W'(4),
        hzd_b         = IC_W'(5),
        hzd_jr        = IC_W'(6),
        hzd_jal       = IC_W'(7),
        hzd_jalr      = IC_W'(8),
        hzd_cp0_load  = IC_W'(9),
        hzd_cp0_store = IC_W'(10)
    } hzd_class_e;

    logic [5:0] e_a1, e_a2, e_a3, m_a2, m_a3, w_a3;
    logic [1:0] e_tnew, m_tnew;

    logic [5:0] d_a3;
    logic [1:0] d_tnew;
    logic       rs_use, rt_use;
    logic [1:0] rs_tuse, rt_tuse;

    function automatic logic hit(input logic [5:0] src, input logic [5:0] dst);
        return (src[4:0] != 5'd0) && !src[5] && (src == dst);
    endfunction

    // Youngest matching stage decides; a match that is not yet ready blocks older stages.
    function automatic logic [1:0] sel_d(input logic [5:0] src, input logic [5:0] ea3,
                                         input logic [1:0] et, input logic [5:0] ma3,
                                         input logic [1:0] mt, input logic [5:0] wa3);
        if (hit(src, ea3))      return (et == 2'd0) ? 2'd1 : 2'd0;
        else if (hit(src, ma3)) return (mt == 2'd0) ? 2'd2 : 2'd0;
        else if (hit(src, wa3)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [5:0] src, input logic [5:0] ma3,
                                         input logic [1:0] mt, input logic [5:0] wa3);
        if (hit(src, ma3))      return (mt == 2'd0) ? 2'd1 : 2'd0;
        else if (hit(src, wa3)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        d_a3   = '0;
        d_tnew = '0;
        case (ic_d)
            hzd_cal_r, hzd_cal_i:     begin d_a3 = A3_d; d_tnew = 2'd1; end
            hzd_load, hzd_cp0_load:   begin d_a3 = A3_d; d_tnew = 2'd2; end
            hzd_jal, hzd_jalr:        begin d_a3 = A3_d; d_tnew = 2'd0; end
`ifdef ERET_EPC_STALL_EN
            hzd_cp0_store:            begin d_a3 = A3_d; d_tnew = 2'd0; end
`endif
            default:                  begin d_a3 = '0;   d_tnew = 2'd0; end
        endcase
    end

    always_comb begin
        rs_use  = 1'b0;
        rs_tuse = '0;
        rt_use  = 1'b0;
        rt_tuse = '0;
        case (ic_d)
            hzd_b, hzd_jr, hzd_jalr: begin rs_use = 1'b1; rs_tuse = 2'd0; end
            hzd_cal_r, hzd_cal_i, hzd_load, hzd_store: begin rs_use = 1'b1; rs_tuse = 2'd1; end
            default: ;
        endcase
        case (ic_d)
            hzd_b:                      begin rt_use = 1'b1; rt_tuse = 2'd0; end
            hzd_cal_r:                  begin rt_use = 1'b1; rt_tuse = 2'd1; end
            hzd_store, hzd_cp0_store:   begin rt_use = 1'b1; rt_tuse = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        stall = (rs_use && ((hit(A1_d, e_a3) && (e_tnew > rs_tuse)) ||
                            (hit(A1_d, m_a3) && (m_tnew > rs_tuse)))) ||
                (rt_use && ((hit(A2_d, e_a3) && (e_tnew > rt_tuse)) ||
                            (hit(A2_d, m_a3) && (m_tnew > rt_tuse))));
`ifdef ERET_EPC_STALL_EN
        if (iseret_d && ((e_a3 == {1'b1, EPC_ADDR}) || (m_a3 == {1'b1, EPC_ADDR})))
            stall = 1'b1;
`endif
        fwd_rs_d = sel_d(A1_d, e_a3, e_tnew, m_a3, m_tnew, w_a3);
        fwd_rt_d = sel_d(A2_d, e_a3, e_tnew, m_a3, m_tnew, w_a3);
        fwd_rs_e = sel_e(e_a1, m_a3, m_tnew, w_a3);
        fwd_rt_e = sel_e(e_a2, m_a3, m_tnew, w_a3);
        fwd_rt_m = hit(m_a2, w_a3);
    end

`ifndef ERET_EPC_STALL_EN
    logic unused_cfg;
    assign unused_cfg = ^{iseret_d, EPC_ADDR};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_a1 <= '0; e_a2 <= '0; e_a3 <= '0; e_tnew <= '0;
            m_a2 <= '0; m_a3 <= '0; m_tnew <= '0;
            w_a3 <= '0;
        end else if (flush) begin
            e_a1 <= '0; e_a2 <= '0; e_a3 <= '0; e_tnew <= '0;
            m_a2 <= '0; m_a3 <= '0; m_tnew <= '0;
            w_a3 <= '0;
        end else begin
            if (stall) begin
                e_a1 <= '0; e_a2 <= '0; e_a3 <= '0; e_tnew <= '0;
            end else begin
                e_a1 <= A1_d; e_a2 <= A2_d; e_a3 <= d_a3; e_tnew <= d_tnew;
            end
            m_a2   <= e_a2;
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_a3   <= m_a3;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed vector table, corner sequences, randomized model comparison.
module tb_hazard_tracker;

    localparam logic [3:0] C_NOP = 4'd0, C_CAL_R = 4'd1, C_CAL_I = 4'd2, C_LOAD = 4'd3,
                           C_STORE = 4'd4, C_B = 4'd5, C_JR = 4'd6, C_JAL = 4'd7,
                           C_JALR = 4'd8, C_CP0_LOAD = 4'd9, C_CP0_STORE = 4'd10;
    localparam logic [5:0] EPC_REG = {1'b1, 5'd14};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] ic_d = '0;
    logic [5:0] A1_d = '0, A2_d = '0, A3_d = '0;
    logic       iseret_d = 1'b0;
    logic       stall, fwd_rt_m;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int n_pass = 0;
    int n_total = 0;

    hazard_tracker #(.EPC_ADDR(5'd14), .IC_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .ic_d(ic_d),
        .A1_d(A1_d), .A2_d(A2_d), .A3_d(A3_d), .iseret_d(iseret_d),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ic;
        logic [5:0] a1, a2, a3;
        logic       eret, fl;
        logic [9:0] exp;
    } vec_t;

    // In-flight instruction as the model sees it: class, sources and architectural destination.
    typedef struct {
        logic [3:0] ic;
        logic [5:0] a1, a2, dst;
    } instr_t;

    instr_t pipe [3];

    function automatic logic [9:0] ex(input int s, input int rsd, input int rtd,
                                      input int rse, input int rte, input int rtm);
        return {s[0], rsd[1:0], rtd[1:0], rse[1:0], rte[1:0], rtm[0]};
    endfunction

    function automatic logic [9:0] got();
        return {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b {stall,rs_d,rt_d,rs_e,rt_e,rt_m}", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [5:0] a1, input logic [5:0] a2,
                         input logic [5:0] a3, input logic er, input logic fl);
        ic_d = ic; A1_d = a1; A2_d = a2; A3_d = a3; iseret_d = er; flush = fl;
    endtask

    function automatic int base_tnew(input logic [3:0] ic);
        case (ic)
            C_CAL_R, C_CAL_I: return 1;
            C_LOAD, C_CP0_LOAD: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic writes(input logic [3:0] ic);
`ifdef ERET_EPC_STALL_EN
        if (ic == C_CP0_STORE) return 1'b1;
`endif
        return ic inside {C_CAL_R, C_CAL_I, C_LOAD, C_CP0_LOAD, C_JAL, C_JALR};
    endfunction

    function automatic int tuse_rs(input logic [3:0] ic);
        if (ic inside {C_B, C_JR, C_JALR}) return 0;
        if (ic inside {C_CAL_R, C_CAL_I, C_LOAD, C_STORE}) return 1;
        return -1;
    endfunction

    function automatic int tuse_rt(input logic [3:0] ic);
        if (ic == C_B) return 0;
        if (ic == C_CAL_R) return 1;
        if (ic inside {C_STORE, C_CP0_STORE}) return 2;
        return -1;
    endfunction

    // Remaining cycles until the result exists, k stages after entering E.
    function automatic int tnew_at(input int k);
        int t;
        t = base_tnew(pipe[k].ic) - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic mhit(input logic [5:0] src, input logic [5:0] dst);
        return (src[4:0] != 0) && (src[5] == 1'b0) && (src == dst);
    endfunction

    function automatic int src_d(input logic [5:0] src);
        for (int k = 0; k < 3; k++)
            if (mhit(src, pipe[k].dst)) return (tnew_at(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int src_e(input logic [5:0] src);
        for (int k = 1; k < 3; k++)
            if (mhit(src, pipe[k].dst)) return (tnew_at(k) == 0) ? k : 0;
        return 0;
    endfunction

    function automatic logic model_stall(input logic [3:0] ic, input logic [5:0] a1,
                                         input logic [5:0] a2, input logic er);
        logic s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (tuse_rs(ic) >= 0 && mhit(a1, pipe[k].dst) && tnew_at(k) > tuse_rs(ic)) s = 1'b1;
            if (tuse_rt(ic) >= 0 && mhit(a2, pipe[k].dst) && tnew_at(k) > tuse_rt(ic)) s = 1'b1;
`ifdef ERET_EPC_STALL_EN
            if (er && pipe[k].dst == EPC_REG) s = 1'b1;
`endif
        end
        return s;
    endfunction

    function automatic logic [5:0] rand_addr();
        int r = $urandom_range(0, 7);
        case (r)
            0: return 6'd0;
            1, 2, 3: return 6'(r);
            4: return 6'd31;
            5: return EPC_REG;
            6: return 6'd35;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    vec_t tbl [21];
    logic exp_eret;

    initial begin
        tbl[0]  = '{C_LOAD,  6'd29, 6'd0, 6'd8,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[1]  = '{C_CAL_R, 6'd8,  6'd9, 6'd10, 1'b0, 1'b0, ex(1,0,0,0,0,0)};
        tbl[2]  = '{C_CAL_R, 6'd8,  6'd9, 6'd10, 1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[3]  = '{C_NOP,   6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,2,0,0)};
        tbl[4]  = '{C_CAL_R, 6'd1,  6'd2, 6'd9,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[5]  = '{C_B,     6'd9,  6'd0, 6'd0,  1'b0, 1'b0, ex(1,0,0,0,0,0)};
        tbl[6]  = '{C_B,     6'd9,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,2,0,0,0,0)};
        tbl[7]  = '{C_JAL,   6'd0,  6'd0, 6'd31, 1'b0, 1'b0, ex(0,0,0,2,0,0)};
        tbl[8]  = '{C_JR,    6'd31, 6'd0, 6'd0,  1'b0, 1'b0, ex(0,1,0,0,0,0)};
        tbl[9]  = '{C_CAL_I, 6'd0,  6'd0, 6'd5,  1'b0, 1'b0, ex(0,0,0,1,0,0)};
        tbl[10] = '{C_CAL_R, 6'd6,  6'd7, 6'd5,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[11] = '{C_STORE, 6'd4,  6'd5, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[12] = '{C_NOP,   6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,1,0)};
        tbl[13] = '{C_NOP,   6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,1)};
        tbl[14] = '{C_CAL_R, 6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[15] = '{C_CAL_R, 6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[16] = '{C_CAL_R, 6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[17] = '{C_LOAD,  6'd29, 6'd0, 6'd8,  1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[18] = '{C_CAL_R, 6'd8,  6'd9, 6'd10, 1'b0, 1'b1, ex(1,0,0,0,0,0)};
        tbl[19] = '{C_CAL_R, 6'd8,  6'd9, 6'd10, 1'b0, 1'b0, ex(0,0,0,0,0,0)};
        tbl[20] = '{C_NOP,   6'd0,  6'd0, 6'd0,  1'b0, 1'b0, ex(0,0,0,0,0,0)};

`ifdef ERET_EPC_STALL_EN
        exp_eret = 1'b1;
`else
        exp_eret = 1'b0;
`endif

        repeat (2) @(negedge clk);
        #1 chk("reset_state", got(), '0);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tbl[i].ic, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].eret, tbl[i].fl);
            #1 chk($sformatf("vec%0d", i), got(), tbl[i].exp);
        end

        @(negedge clk);
        drive(C_CP0_STORE, 6'd0, 6'd3, EPC_REG, 1'b0, 1'b0);
        #1 chk("mtc0_issue", got(), '0);
        @(negedge clk);
        drive(C_NOP, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        #1 chk("eret_mtc0_in_e", got(), {exp_eret, 9'd0});
        @(negedge clk);
        #1 chk("eret_mtc0_in_m", got(), {exp_eret, 9'd0});
        @(negedge clk);
        #1 chk("eret_mtc0_in_w", got(), '0);

        @(negedge clk);
        drive(C_LOAD, 6'd29, 6'd0, 6'd8, 1'b0, 1'b0);
        @(negedge clk);
        drive(C_CAL_R, 6'd8, 6'd9, 6'd10, 1'b0, 1'b0);
        #1 chk("pre_reset_stall", got(), ex(1,0,0,0,0,0));
        #1 reset_n = 1'b0;
        #1 chk("async_reset_clears", got(), '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 3; k++) pipe[k] = '{C_NOP, 6'd0, 6'd0, 6'd0};
        for (int n = 0; n < 3000; n++) begin
            logic [9:0] e;
            logic       s;
            instr_t     d;
            @(negedge clk);
            drive(4'($urandom_range(0, 11)), rand_addr(), rand_addr(), rand_addr(),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
            #1;
            s = model_stall(ic_d, A1_d, A2_d, iseret_d);
            e = {s, 2'(src_d(A1_d)), 2'(src_d(A2_d)), 2'(src_e(pipe[0].a1)),
                 2'(src_e(pipe[0].a2)), mhit(pipe[1].a2, pipe[2].dst)};
            chk("rand", got(), e);
            d = '{ic_d, A1_d, A2_d, writes(ic_d) ? A3_d : 6'd0};
            @(posedge clk);
            if (flush) begin
                for (int k = 0; k < 3; k++) pipe[k] = '{C_NOP, 6'd0, 6'd0, 6'd0};
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = s ? '{C_NOP, 6'd0, 6'd0, 6'd0} : d;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
